linelength_extract: RTL and testbench
=====================================

// Module: linelength_extract
// PURPOSE
//  Computes the line-length feature LL[n] = sum |x[k]-x[k-1]| over the last WIN_LEN samples of one
//  EEG channel.
//  It updates a running sum on every accepted sample using a circular buffer of absolute differences.
//  Sits directly upstream of the baseline block: dout feeds baseline.din (25-bit, signed port, always >= 0).
//  en uses the same active-low convention as the baseline block.
// PARAMETERS
//  SAMPLE_WIDTH  16   signed ADC sample width
//  WIN_LEN       250  window length in samples (1 s at 250 Hz)
//  ADDR_WIDTH    8    circular-buffer address width, 2^ADDR_WIDTH >= WIN_LEN
//  OUT_WIDTH     25   output width = SAMPLE_WIDTH+ADDR_WIDTH+1 (MSB always 0)
// PORTS
//  clk         in   1             system clock
//  rst         in   1             reset, asynchronous, active-low
//  en          in   1             enable, active-low; en=1 stalls the block
//  din_valid   in   1             din carries a new sample this cycle
//  din         in   SAMPLE_WIDTH  signed sample
//  dout        out  OUT_WIDTH     line-length of the last WIN_LEN differences
//  dout_valid  out  1             one-cycle pulse: dout updated this cycle
//  win_full    out  1             window holds WIN_LEN differences
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is asynchronous and active-low.
//  - Reset (rst=0), effective immediately:
//    - dout=0, dout_valid=0, win_full=0.
//    - fill count=0, write pointer=0, sum=0, state=EMPTY.
//    - Buffer contents need no reset; fill-count masking makes them don't-care.
//  - Accept: a sample is accepted when en==0 && din_valid==1.
//    - With en==1, all state and outputs hold, and dout_valid=0.
//  - States:
//    - EMPTY: no previous sample yet. The first accepted sample is stored as prev; no difference is
//      computed. Next state is PRIME.
//    - PRIME: each accepted sample computes d=|din-prev| and writes it to buf[wptr].
//      - sum <= sum + d; fill++.
//      - When fill reaches WIN_LEN, go to RUN.
//    - RUN: each accepted sample does sum <= sum + d - buf[wptr] (the oldest entry), then overwrites
//      buf[wptr] with d.
//  - Pointer: wptr increments mod WIN_LEN; it wraps from WIN_LEN-1 to 0 (not to 2^ADDR_WIDTH).
//  - Arithmetic:
//    - The difference is computed at SAMPLE_WIDTH+1 bits signed; its absolute value is stored
//      unsigned on SAMPLE_WIDTH bits (max 65535).
//    - sum is unsigned on OUT_WIDTH-1 bits; the maximum is 65535*250 = 16383750, so there is no
//      overflow and no saturation.
//    - dout = {1'b0, sum}.
//  - Latency: registered, 1 cycle. dout/dout_valid reflect the sample accepted on the previous edge.
//  - dout_valid pulses only for samples accepted while win_full=1 after the update, i.e. starting
//    with the sample that completes the window.
//    - The first valid output is therefore the (WIN_LEN+1)-th accepted sample.
//    - In PRIME, dout tracks the partial sum but dout_valid=0.
//  - dout holds its value between pulses. The baseline block samples dout every clk, so the held
//    value is intentional.
//  - win_full rises with the first dout_valid and stays high until reset.
//  - Back-to-back accepts (din_valid=1 every cycle) are supported at full rate with no bubbles.
//  - Buffer read-before-write: in RUN, the old value at wptr is used in the same cycle it is
//    overwritten.
//  - If rst is asserted mid-window, the block returns to EMPTY. A restart requires WIN_LEN+1 new
//    samples before dout_valid.
// TESTING
//  1. Reset, then din=100 constant for 300 accepts:
//     - dout=0 throughout.
//     - First dout_valid is on accept #251; win_full=1 from then on.
//  2. Alternating +1000/-1000 for 260 accepts:
//     - dout=500000 on accept #251 and every accept after.
//  3. Alternating 32767/-32768:
//     - dout=16383750 once full, with dout[24]=0 (no wrap).
//  4. Running at 0, inject a step to 400 then hold:
//     - dout=400 for 250 accepts, then returns to 0 exactly when the step difference ages out.
//  5. Mid-run, set en=1 for 10 cycles while din changes and din_valid=1:
//     - dout and win_full hold; no dout_valid pulses.
//     - After resume, the next difference is taken against the last accepted sample.
//  6. Async rst pulse mid-PRIME and mid-RUN (not clock-aligned):
//     - Outputs are 0 immediately.
//     - The next dout_valid appears only after 251 new accepts.
//     - The din_valid duty cycle is randomised with a reference-model compare.

Source files
------------

// File: rtl/linelength_extract.sv
// linelength_extract: running line-length (sum of |x[k]-x[k-1]|) over the last WIN_LEN samples,
// kept as a circular buffer of absolute differences plus a running sum.
module linelength_extract #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int WIN_LEN      = 250,
   parameter int ADDR_WIDTH   = 8,
   parameter int OUT_WIDTH    = 25
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    din_valid,
   input  logic [SAMPLE_WIDTH-1:0] din,
   output logic [OUT_WIDTH-1:0]    dout,
   output logic                    dout_valid,
   output logic                    win_full
);
   localparam int SUM_W = OUT_WIDTH - 1;
   localparam logic [1:0] EMPTY = 2'd0, PRIME = 2'd1, RUN = 2'd2;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WIN_LEN - 1);
   logic [1:0]              state;
   logic [SAMPLE_WIDTH-1:0] prev, ad, oldest;
   logic [SAMPLE_WIDTH-1:0] mem [WIN_LEN];
   logic [ADDR_WIDTH-1:0]   wptr, fill;
   logic [SUM_W-1:0]        sum, sum_next;
   logic [SAMPLE_WIDTH:0]   diff;
   logic                    acc, wr, full_next;
   always_comb begin
      acc = !en && din_valid;
      wr = acc && state != EMPTY;
      diff = {din[SAMPLE_WIDTH-1], din} - {prev[SAMPLE_WIDTH-1], prev};
      ad = diff[SAMPLE_WIDTH] ? SAMPLE_WIDTH'(-diff) : diff[SAMPLE_WIDTH-1:0];
      oldest = mem[wptr];
      sum_next = state == RUN   ? sum + SUM_W'(ad) - SUM_W'(oldest) :
                 state == PRIME ? sum + SUM_W'(ad) : sum;
      full_next = state == RUN || (state == PRIME && fill == LAST);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= EMPTY;
         prev <= '0;
         wptr <= '0;
         fill <= '0;
         sum <= '0;
         dout <= '0;
         dout_valid <= 1'b0;
         win_full <= 1'b0;
      end else begin
         dout_valid <= acc && full_next;
         if (acc) begin
            prev <= din;
            sum <= sum_next;
            dout <= {1'b0, sum_next};
            win_full <= full_next;
            state <= state == EMPTY ? PRIME : full_next ? RUN : state;
            if (state != EMPTY) wptr <= wptr == LAST ? '0 : wptr + 1'b1;
            if (state == PRIME) fill <= fill + 1'b1;
         end
      end
   // Oldest entry is read combinationally above before this write lands (read-before-write).
   always_ff @(posedge clk)
      if (wr) mem[wptr] <= ad;
endmodule

// File: tb/tb_linelength_extract.sv
// tb_linelength_extract: directed and randomized checks of linelength_extract against a
// queue-of-samples line-length model, with async reset pulses mid-PRIME and mid-RUN.
module tb_linelength_extract;
   localparam int WIN = 250;
   logic        clk = 0, rst = 1, en = 1, din_valid = 0;
   logic [15:0] din = '0;
   logic [24:0] dout;
   logic        dout_valid, win_full;
   int          n_cmp = 0, n_bad = 0;
   int          hist[$];
   logic [24:0] exp_dout = '0;
   logic        exp_valid = 0, exp_full = 0;
   int          first_acc = 0;
   int          pulses;

   linelength_extract dut (
      .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
      .dout(dout), .dout_valid(dout_valid), .win_full(win_full)
   );

   always #5 clk = ~clk;

   // Model: full history of accepted samples since reset; LL recomputed from scratch each accept.
   always @(negedge rst) begin
      hist.delete();
      exp_dout = '0;
      exp_valid = 0;
      exp_full = 0;
      first_acc = 0;
   end

   always @(posedge clk) begin
      if (rst && !en && din_valid) begin
         int n, s, d;
         hist.push_back(int'($signed(din)));
         n = hist.size();
         s = 0;
         for (int k = (n > WIN ? n - WIN : 1); k < n; k++) begin
            d = hist[k] - hist[k-1];
            s += d < 0 ? -d : d;
         end
         exp_dout = 25'(s);
         exp_valid = n > WIN;
         exp_full = n > WIN;
      end else
         exp_valid = 0;
   end

   always @(negedge clk) begin
      n_cmp += 3;
      if (dout !== exp_dout) begin
         n_bad++;
         $display("FAIL dout @%0t: got %0d expected %0d", $time, dout, exp_dout);
      end
      if (dout_valid !== exp_valid) begin
         n_bad++;
         $display("FAIL dout_valid @%0t: got %b expected %b", $time, dout_valid, exp_valid);
      end
      if (win_full !== exp_full) begin
         n_bad++;
         $display("FAIL win_full @%0t: got %b expected %b", $time, win_full, exp_full);
      end
      if (dout_valid === 1'b1 && first_acc == 0) first_acc = hist.size();
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask

   task automatic send(input logic [15:0] x);
      en = 0;
      din_valid = 1;
      din = x;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst(input string nm);
      din_valid = 0;
      @(posedge clk);
      #3 rst = 0;
      #1;
      chk({nm, "_dout"}, 32'(dout), 0);
      chk({nm, "_valid"}, 32'(dout_valid), 0);
      chk({nm, "_full"}, 32'(win_full), 0);
      #3 rst = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         en = $urandom_range(0, 9) == 0;
         din_valid = $urandom_range(0, 2) != 0;
         din = 16'($urandom_range(0, 65535));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1 rst = 0;
      #9;
      chk("reset_dout", 32'(dout), 0);
      chk("reset_valid", 32'(dout_valid), 0);
      chk("reset_full", 32'(win_full), 0);
      #13 rst = 1;
      @(posedge clk);
      #1;
      // constant input: LL stays 0, first valid on accept 251
      for (int i = 1; i <= 300; i++) send(16'd100);
      chk("t1_first_valid", 32'(first_acc), 251);
      chk("t1_dout", 32'(dout), 0);
      chk("t1_full", 32'(win_full), 1);
      // +-1000 alternating: 250 * 2000
      for (int i = 1; i <= 260; i++) begin
         send((i % 2) ? 16'd1000 : 16'hFC18);
         if (i == 251) chk("t2_dout_251", 32'(dout), 500000);
      end
      chk("t2_dout_260", 32'(dout), 500000);
      // full-scale alternation: maximum window sum, no wrap into MSB
      for (int i = 1; i <= 260; i++) send((i % 2) ? 16'h7FFF : 16'h8000);
      chk("t3_dout", 32'(dout), 16383750);
      chk("t3_msb", 32'(dout[24]), 0);
      // settle at 0, then a single 400 step that ages out after 250 accepts
      for (int i = 1; i <= 260; i++) send(16'd0);
      chk("t4_zero", 32'(dout), 0);
      for (int k = 1; k <= 251; k++) begin
         send(16'd400);
         if (k == 1) chk("t4_step_first", 32'(dout), 400);
         if (k == 250) chk("t4_step_last", 32'(dout), 400);
         if (k == 251) chk("t4_aged_out", 32'(dout), 0);
      end
      // stall: en=1 with din changing must not be accepted
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         en = 1;
         din_valid = 1;
         din = 16'($urandom_range(0, 65535));
         @(posedge clk);
         #1;
         if (dout_valid) pulses++;
      end
      chk("t5_pulses", 32'(pulses), 0);
      chk("t5_hold_dout", 32'(dout), 0);
      chk("t5_hold_full", 32'(win_full), 1);
      send(16'd1000);
      chk("t5_resume", 32'(dout), 600);
      // async resets mid-RUN and mid-PRIME with random duty cycle
      pulse_rst("t6_run_rst");
      rand_run(250);
      chk("t6_prime_no_valid", 32'(first_acc), 0);
      pulse_rst("t6_prime_rst");
      rand_run(1000);
      chk("t6_first_valid", 32'(first_acc), 251);
      din_valid = 0;
      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
